core_rrv_dmem_arb: RTL and testbench

Two-requester arbiter and sequencer for the single-port D_MEM inside core_rrv_mem_wrap. It shares the memory port between the core pipeline (load/store stage) and the fabric F2C path. The core has default priority. A starvation counter guarantees fabric forward progress, and a response FIFO absorbs fabric back-pressure. The block sits between the core/fabric request paths and d_mem, which has 1-cycle read latency.

---
 rtl/core_rrv_dmem_arb.sv | 162 ++++++++++++++++
 tb/tb_core_rrv_dmem_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_rrv_dmem_arb.sv
// Core/fabric arbiter and sequencer for the single-port D_MEM (1-cycle read latency).
// Optional performance counters are enabled with `define CORE_RRV_DMEM_ARB_PMON_EN.
module core_rrv_dmem_arb #(
  parameter int unsigned STARVE_MAX     = 4,
  parameter int unsigned RSP_FIFO_DEPTH = 4,
  parameter int unsigned TAG_W          = 8
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             CoreReqValid,
  input  logic             CoreReqWrEn,
  input  logic [31:0]      CoreReqAddr,
  input  logic [31:0]      CoreReqData,
  input  logic [3:0]       CoreReqByteEn,
  output logic             CoreReqReady,
  output logic             CoreRspValid,
  output logic [31:0]      CoreRspData,
  input  logic             FabReqValid,
  input  logic             FabReqWrEn,
  input  logic [31:0]      FabReqAddr,
  input  logic [31:0]      FabReqData,
  input  logic [3:0]       FabReqByteEn,
  input  logic [TAG_W-1:0] FabReqTag,
  output logic             FabReqReady,
  output logic             FabRspValid,
  output logic [31:0]      FabRspData,
  output logic [TAG_W-1:0] FabRspTag,
  input  logic             FabRspReady,
  output logic             MemRdEn,
  output logic             MemWrEn,
  output logic [31:0]      MemAddr,
  output logic [31:0]      MemWrData,
  output logic [3:0]       MemByteEn,
  input  logic [31:0]      MemRdData
`ifdef CORE_RRV_DMEM_ARB_PMON_EN
  ,
  output logic [31:0]      PmonCoreStall,
  output logic [31:0]      PmonFabGrant,
  output logic [31:0]      PmonForced
`endif
);

  localparam int unsigned PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [3:0]       starveCnt;
  logic [CNT_W-1:0] fifoCount;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             rdValid;
  logic             rdOwner;
  logic [TAG_W-1:0] rdTag;
  logic [31:0]      fifoData [RSP_FIFO_DEPTH];
  logic [TAG_W-1:0] fifoTag  [RSP_FIFO_DEPTH];

  logic             rdInflight;
  logic [CNT_W:0]   occupancy;
  logic             fabOk;
  logic             forced;
  logic             grantCore;
  logic             grantFab;
  logic             push;
  logic             pop;
  logic             fifoFull;

  // In-flight fabric read already owns a FIFO slot, so it counts against room.
  assign rdInflight = rdValid & rdOwner;
  assign occupancy  = {1'b0, fifoCount} + (CNT_W+1)'(rdInflight);
  assign fabOk      = FabReqValid & (FabReqWrEn | (occupancy < (CNT_W+1)'(RSP_FIFO_DEPTH)));
  assign forced     = (starveCnt == 4'(STARVE_MAX));

  assign grantFab  = Rst & fabOk & (forced | ~CoreReqValid);
  assign grantCore = Rst & CoreReqValid & ~grantFab;

  assign CoreReqReady = grantCore;
  assign FabReqReady  = grantFab;

  always_comb begin
    MemRdEn   = 1'b0;
    MemWrEn   = 1'b0;
    MemAddr   = '0;
    MemWrData = '0;
    MemByteEn = '0;
    if (grantCore) begin
      MemRdEn   = ~CoreReqWrEn;
      MemWrEn   = CoreReqWrEn;
      MemAddr   = CoreReqAddr;
      MemWrData = CoreReqData;
      MemByteEn = CoreReqByteEn;
    end else if (grantFab) begin
      MemRdEn   = ~FabReqWrEn;
      MemWrEn   = FabReqWrEn;
      MemAddr   = FabReqAddr;
      MemWrData = FabReqData;
      MemByteEn = FabReqByteEn;
    end
  end

  assign CoreRspValid = rdValid & ~rdOwner;
  assign CoreRspData  = CoreRspValid ? MemRdData : '0;

  assign fifoFull    = (fifoCount == CNT_W'(RSP_FIFO_DEPTH));
  assign push        = rdValid & rdOwner;
  assign FabRspValid = Rst & (fifoCount != '0);
  assign pop         = FabRspValid & FabRspReady;
  assign FabRspData  = fifoData[rdPtr];
  assign FabRspTag   = fifoTag[rdPtr];

  always_ff @(posedge Clock) begin
    if (!Rst) begin
      starveCnt <= '0;
      rdValid   <= 1'b0;
      rdOwner   <= 1'b0;
      rdTag     <= '0;
      fifoCount <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
    end else begin
      if (!FabReqValid || grantFab) begin
        starveCnt <= '0;
      end else if (!forced) begin
        starveCnt <= starveCnt + 4'd1;
      end

      rdValid <= (grantCore & ~CoreReqWrEn) | (grantFab & ~FabReqWrEn);
      rdOwner <= grantFab;
      rdTag   <= FabReqTag;

      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + CNT_W'(1);
        2'b01:   fifoCount <= fifoCount - CNT_W'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      fifoData[wrPtr] <= MemRdData;
      fifoTag[wrPtr]  <= rdTag;
    end
  end

  overflowChk: assert property (@(posedge Clock) disable iff (!Rst) !(push && !pop && fifoFull));

`ifdef CORE_RRV_DMEM_ARB_PMON_EN
  always_ff @(posedge Clock) begin
    if (!Rst) begin
      PmonCoreStall <= '0;
      PmonFabGrant  <= '0;
      PmonForced    <= '0;
    end else begin
      if (CoreReqValid && !grantCore) PmonCoreStall <= PmonCoreStall + 32'd1;
      if (grantFab)                   PmonFabGrant  <= PmonFabGrant + 32'd1;
      if (grantFab && forced)         PmonForced    <= PmonForced + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_rrv_dmem_arb.sv
// Directed bench for core_rrv_dmem_arb with a behavioural 1-cycle-latency memory.
module tb_core_rrv_dmem_arb;

  logic        Clock = 1'b0;
  logic        Rst;
  logic        CoreReqValid, CoreReqWrEn;
  logic [31:0] CoreReqAddr, CoreReqData;
  logic [3:0]  CoreReqByteEn;
  logic        CoreReqReady, CoreRspValid;
  logic [31:0] CoreRspData;
  logic        FabReqValid, FabReqWrEn;
  logic [31:0] FabReqAddr, FabReqData;
  logic [3:0]  FabReqByteEn;
  logic [7:0]  FabReqTag;
  logic        FabReqReady, FabRspValid;
  logic [31:0] FabRspData;
  logic [7:0]  FabRspTag;
  logic        FabRspReady;
  logic        MemRdEn, MemWrEn;
  logic [31:0] MemAddr, MemWrData;
  logic [3:0]  MemByteEn;
  logic [31:0] MemRdData = '0;
`ifdef CORE_RRV_DMEM_ARB_PMON_EN
  logic [31:0] PmonCoreStall, PmonFabGrant, PmonForced;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] mem [0:1023];

  core_rrv_dmem_arb #(.STARVE_MAX(4), .RSP_FIFO_DEPTH(4), .TAG_W(8)) dut (
    .Clock(Clock), .Rst(Rst),
    .CoreReqValid(CoreReqValid), .CoreReqWrEn(CoreReqWrEn), .CoreReqAddr(CoreReqAddr),
    .CoreReqData(CoreReqData), .CoreReqByteEn(CoreReqByteEn), .CoreReqReady(CoreReqReady),
    .CoreRspValid(CoreRspValid), .CoreRspData(CoreRspData),
    .FabReqValid(FabReqValid), .FabReqWrEn(FabReqWrEn), .FabReqAddr(FabReqAddr),
    .FabReqData(FabReqData), .FabReqByteEn(FabReqByteEn), .FabReqTag(FabReqTag),
    .FabReqReady(FabReqReady), .FabRspValid(FabRspValid), .FabRspData(FabRspData),
    .FabRspTag(FabRspTag), .FabRspReady(FabRspReady),
    .MemRdEn(MemRdEn), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemByteEn(MemByteEn), .MemRdData(MemRdData)
`ifdef CORE_RRV_DMEM_ARB_PMON_EN
    , .PmonCoreStall(PmonCoreStall), .PmonFabGrant(PmonFabGrant), .PmonForced(PmonForced)
`endif
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (MemWrEn)
      for (int b = 0; b < 4; b++)
        if (MemByteEn[b]) mem[MemAddr[11:2]][8*b +: 8] <= MemWrData[8*b +: 8];
    if (MemRdEn) MemRdData <= mem[MemAddr[11:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 3 units later.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    CoreReqValid = 0; CoreReqWrEn = 0; CoreReqAddr = '0; CoreReqData = '0; CoreReqByteEn = '0;
    FabReqValid = 0; FabReqWrEn = 0; FabReqAddr = '0; FabReqData = '0; FabReqByteEn = '0;
    FabReqTag = '0;
  endtask

  task automatic fabRead(input logic [7:0] t);
    FabReqValid = 1; FabReqWrEn = 0; FabReqTag = t;
    FabReqAddr = 32'h0040_0200 + 32'(t) * 4;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h004] = 32'hDEAD_BEEF;
    for (int t = 1; t < 32; t++) mem[10'h080 + t] = 32'hA000_0000 + 32'(t);

    idle();
    Rst = 0; FabRspReady = 1;
    CoreReqValid = 1; FabReqValid = 1; FabReqWrEn = 1;
    tick(); tick();
    #3;
    chk("rst_core_ready", 32'(CoreReqReady), 32'd0);
    chk("rst_fab_ready",  32'(FabReqReady),  32'd0);
    chk("rst_mem_strobe", 32'({MemRdEn, MemWrEn}), 32'd0);
    chk("rst_fab_rsp",    32'(FabRspValid),  32'd0);
    chk("rst_core_rsp",   32'(CoreRspValid), 32'd0);

    idle(); Rst = 1;
    tick();

    // Core-only load
    CoreReqValid = 1; CoreReqAddr = 32'h0040_0010;
    #3;
    chk("ld_ready", 32'(CoreReqReady), 32'd1);
    chk("ld_rden",  32'(MemRdEn), 32'd1);
    chk("ld_addr",  MemAddr, 32'h0040_0010);
    tick(); idle(); #3;
    chk("ld_rsp_valid", 32'(CoreRspValid), 32'd1);
    chk("ld_rsp_data",  CoreRspData, 32'hDEAD_BEEF);
    chk("ld_no_fabrsp", 32'(FabRspValid), 32'd0);
    tick(); #3;
    chk("ld_rsp_once", 32'(CoreRspValid), 32'd0);

    // Contention: core loads, fabric writes, both held for 10 cycles
    tick();
    CoreReqValid = 1; CoreReqAddr = 32'h0040_0010;
    FabReqValid = 1; FabReqWrEn = 1; FabReqAddr = 32'h0040_0100;
    FabReqData = 32'h5555_AAAA; FabReqByteEn = 4'hF;
    for (int i = 0; i < 10; i++) begin
      #3;
      chk($sformatf("cont_core_%0d", i), 32'(CoreReqReady), 32'((i != 4) && (i != 9)));
      chk($sformatf("cont_fab_%0d", i),  32'(FabReqReady),  32'((i == 4) || (i == 9)));
      chk($sformatf("cont_wr_%0d", i),   32'(MemWrEn),      32'((i == 4) || (i == 9)));
      tick();
    end
    idle();
`ifdef CORE_RRV_DMEM_ARB_PMON_EN
    #3;
    chk("pmon_forced", PmonForced,    32'd2);
    chk("pmon_fabgnt", PmonFabGrant,  32'd2);
    chk("pmon_stall",  PmonCoreStall, 32'd2);
`endif
    chk("cont_mem_written", mem[10'h040], 32'h5555_AAAA);

    // Back-pressure: six reads with FabRspReady low
    tick(); tick();
    FabRspReady = 0;
    for (int k = 0; k < 4; k++) begin
      fabRead(8'(k + 1));
      #3;
      chk($sformatf("bp_accept_%0d", k + 1), 32'(FabReqReady), 32'd1);
      tick();
    end
    fabRead(8'd5);
    #3; chk("bp_reject_a", 32'(FabReqReady), 32'd0);
    tick(); #3;
    chk("bp_reject_b", 32'(FabReqReady), 32'd0);
    chk("bp_full_tag", 32'(FabRspTag), 32'd1);
    tick();
    FabRspReady = 1; #3;
    chk("bp_pop1_tag",  32'(FabRspTag), 32'd1);
    chk("bp_pop1_data", FabRspData, 32'hA000_0001);
    chk("bp_still_full", 32'(FabReqReady), 32'd0);
    tick(); #3;
    chk("bp_pop2_tag", 32'(FabRspTag), 32'd2);
    chk("bp_acc5",     32'(FabReqReady), 32'd1);
    tick(); fabRead(8'd6); #3;
    chk("bp_pop3_tag", 32'(FabRspTag), 32'd3);
    chk("bp_acc6",     32'(FabReqReady), 32'd1);
    tick(); idle(); #3;
    chk("bp_pop4_tag", 32'(FabRspTag), 32'd4);
    tick(); #3;
    chk("bp_pop5_tag",  32'(FabRspTag), 32'd5);
    chk("bp_pop5_data", FabRspData, 32'hA000_0005);
    tick(); #3;
    chk("bp_pop6_tag",  32'(FabRspTag), 32'd6);
    chk("bp_pop6_data", FabRspData, 32'hA000_0006);
    tick(); #3;
    chk("bp_empty", 32'(FabRspValid), 32'd0);

    // Core store then fabric read of the same word
    tick();
    CoreReqValid = 1; CoreReqWrEn = 1; CoreReqAddr = 32'h0040_0020;
    CoreReqData = 32'h1234_5678; CoreReqByteEn = 4'hF;
    #3; chk("ord_st_ready", 32'(CoreReqReady), 32'd1);
    tick(); idle();
    FabReqValid = 1; FabReqAddr = 32'h0040_0020; FabReqTag = 8'h77;
    #3; chk("ord_rd_ready", 32'(FabReqReady), 32'd1);
    tick(); idle(); tick(); #3;
    chk("ord_rsp_valid", 32'(FabRspValid), 32'd1);
    chk("ord_rsp_data",  FabRspData, 32'h1234_5678);
    chk("ord_rsp_tag",   32'(FabRspTag), 32'h77);
    tick();

    // Reset with two FIFO entries and a read in flight
    FabRspReady = 0;
    for (int k = 0; k < 3; k++) begin
      fabRead(8'h11 + 8'(k));
      tick();
    end
    CoreReqValid = 1; CoreReqAddr = 32'h0040_0010;
    #3; chk("mr_pre_valid", 32'(FabRspValid), 32'd1);
    Rst = 0; #1;
    chk("mr_core_ready_rst", 32'(CoreReqReady), 32'd0);
    chk("mr_fab_ready_rst",  32'(FabReqReady),  32'd0);
    tick(); #3;
    chk("mr_fabrsp",     32'(FabRspValid),  32'd0);
    chk("mr_corersp",    32'(CoreRspValid), 32'd0);
    chk("mr_core_ready", 32'(CoreReqReady), 32'd0);
    chk("mr_fab_ready",  32'(FabReqReady),  32'd0);
    chk("mr_rden",       32'(MemRdEn),      32'd0);
    Rst = 1; idle(); FabRspReady = 1;
    tick(); #3;
    chk("mr_no_stale", 32'(FabRspValid), 32'd0);
    tick();
    CoreReqValid = 1; CoreReqAddr = 32'h0040_0010;
    #3; chk("mr_ld_ready", 32'(CoreReqReady), 32'd1);
    tick(); idle(); #3;
    chk("mr_ld_valid", 32'(CoreRspValid), 32'd1);
    chk("mr_ld_data",  CoreRspData, 32'hDEAD_BEEF);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
